// File: rtl/dcache_direct_mapped_if.sv
// CPU data-port and block-memory port bundle of the direct-mapped data cache.
// The cache takes the slave view; the CPU/memory side takes the master view.
interface dcache_direct_mapped_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache: combinational read hits,
// dirty-victim write-back followed by a block fill on a miss.
module dcache_direct_mapped #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dcache_direct_mapped_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int TAG_W  = 8 - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH} state_t;

  state_t                  state, next_state;
  logic [NUM_BLOCKS-1:0]   valid, dirty;
  logic [TAG_W-1:0]        tags  [NUM_BLOCKS];
  logic [LINE_W-1:0]       lines [NUM_BLOCKS];

  logic [TAG_W-1:0]        addr_tag;
  logic [IDX_W-1:0]        idx;
  logic [OFF_W-1:0]        off;
  logic                    req, hit, wr_hit, fill_en;
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        fill_tag;

  logic                    mem_read_q, mem_write_q, mem_read_d, mem_write_d;
  logic [IDX_W+TAG_W-1:0]  mem_address_q, mem_address_d;
  logic [LINE_W-1:0]       mem_writedata_q, mem_writedata_d;

  assign addr_tag = bus.address[7 -: TAG_W];
  assign idx      = bus.address[OFF_W +: IDX_W];
  assign off      = bus.address[OFF_W-1:0];
  assign req      = bus.read | bus.write;
  assign hit      = valid[idx] && (tags[idx] == addr_tag);
  assign wr_hit   = (state == IDLE) && bus.write && hit;
  assign fill_en  = (state == FETCH) && !bus.mem_busywait;
  // The fill targets the block latched on entry to FETCH, so a dropped or
  // changed request cannot redirect it.
  assign fill_idx = mem_address_q[IDX_W-1:0];
  assign fill_tag = mem_address_q[IDX_W +: TAG_W];

  assign bus.readdata      = (bus.read && !bus.write && hit) ? lines[idx][{off, 3'b000} +: 8] : 8'h00;
  assign bus.busywait      = (req && !hit) || (state != IDLE);
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  // State register and registered memory-request outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state           <= next_state;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (req && !hit) next_state = (valid[idx] && dirty[idx]) ? WRITE_BACK : FETCH;
      WRITE_BACK: if (!bus.mem_busywait) next_state = FETCH;
      FETCH:      if (!bus.mem_busywait) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered request outputs
  always_comb begin
    mem_read_d      = (next_state == FETCH);
    mem_write_d     = (next_state == WRITE_BACK);
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    if (state == IDLE && next_state == WRITE_BACK) begin
      mem_address_d   = {tags[idx], idx};
      mem_writedata_d = lines[idx];
    end else if (state != FETCH && next_state == FETCH) begin
      mem_address_d   = {addr_tag, idx};
    end
  end

  // Line status bits
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
      dirty[fill_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset
  always_ff @(posedge clock) begin
    if (fill_en) begin
      lines[fill_idx] <= bus.mem_readdata;
      tags[fill_idx]  <= fill_tag;
    end else if (wr_hit) begin
      lines[idx][{off, 3'b000} +: 8] <= bus.writedata;
    end
  end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a fixed-latency block memory model.
module tb_dcache_direct_mapped;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem [64];
  bit          mem_loaded = 1'b0;
  int          cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dcache_direct_mapped_if bus();

  dcache_direct_mapped dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Memory holds busywait for LAT edges after a request rises, then completes.
  assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (cnt < LAT);
  assign bus.mem_readdata = mem[bus.mem_address];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int b = 0; b < 64; b++) mem[b] <= 32'h44332211 + b * 32'h01010101;
      mem_loaded <= 1'b1;
    end else if (bus.mem_read | bus.mem_write) begin
      if (cnt < LAT) cnt <= cnt + 1;
      else begin
        cnt <= 0;
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      end
    end else begin
      cnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk); #1;
      if (!bus.busywait) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL reset_busywait got %0h want 0", bus.busywait); end
    tests++; if (bus.mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read got %0h want 0", bus.mem_read); end
    tests++; if (bus.mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write got %0h want 0", bus.mem_write); end
    tests++; if (bus.mem_address !== 6'h00) begin fails++; $display("FAIL reset_mem_address got %0h want 00", bus.mem_address); end
    tests++; if (bus.mem_writedata !== 32'h0) begin fails++; $display("FAIL reset_mem_writedata got %0h want 0", bus.mem_writedata); end
    tests++; if (bus.readdata !== 8'h00) begin fails++; $display("FAIL reset_readdata got %0h want 00", bus.readdata); end
  endtask

  task automatic test_clean_miss;
    int c;
    bus.read = 1'b1; bus.address = 8'h00; #1;
    tests++; if (bus.busywait !== 1'b1) begin fails++; $display("FAIL miss_busywait got %0h want 1", bus.busywait); end
    tests++; if (bus.mem_read !== 1'b0) begin fails++; $display("FAIL miss_mem_read_early got %0h want 0", bus.mem_read); end
    @(negedge clk); #1;
    tests++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL miss_mem_read got %0h want 1", bus.mem_read); end
    tests++; if (bus.mem_address !== 6'h00) begin fails++; $display("FAIL miss_mem_address got %0h want 00", bus.mem_address); end
    wait_ready(c);
    tests++; if (c !== 3) begin fails++; $display("FAIL miss_fetch_cycles got %0d want 3", c); end
    tests++; if (bus.readdata !== 8'h11) begin fails++; $display("FAIL miss_readdata got %0h want 11", bus.readdata); end
    bus.address = 8'h03; #1;
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL hit_busywait got %0h want 0", bus.busywait); end
    tests++; if (bus.readdata !== 8'h44) begin fails++; $display("FAIL hit_readdata got %0h want 44", bus.readdata); end
    @(negedge clk); #1;
    tests++; if (bus.mem_read !== 1'b0) begin fails++; $display("FAIL hit_no_traffic got %0h want 0", bus.mem_read); end
  endtask

  task automatic test_write_hit;
    int c;
    bus.read = 1'b1; bus.address = 8'h05;
    wait_ready(c);
    tests++; if (bus.readdata !== 8'h23) begin fails++; $display("FAIL wr_fill_readdata got %0h want 23 (cyc %0d)", bus.readdata, c); end
    bus.read = 1'b0; bus.write = 1'b1; bus.writedata = 8'hAA; #1;
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL wr_hit_busywait got %0h want 0", bus.busywait); end
    @(negedge clk); #1;
    tests++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin fails++; $display("FAIL wr_hit_traffic got %0b want 00", {bus.mem_read, bus.mem_write}); end
    bus.write = 1'b0; bus.read = 1'b1; #1;
    tests++; if (bus.readdata !== 8'hAA) begin fails++; $display("FAIL wr_hit_readback got %0h want aa", bus.readdata); end
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL wr_hit_readback_busy got %0h want 0", bus.busywait); end
  endtask

  task automatic test_dirty_miss;
    int c;
    bus.read = 1'b1; bus.address = 8'h25; #1;
    tests++; if (bus.busywait !== 1'b1) begin fails++; $display("FAIL dm_busywait got %0h want 1", bus.busywait); end
    @(negedge clk); #1;
    tests++; if ({bus.mem_write, bus.mem_read} !== 2'b10) begin fails++; $display("FAIL dm_wb_req got %0b want 10", {bus.mem_write, bus.mem_read}); end
    tests++; if (bus.mem_address !== 6'h01) begin fails++; $display("FAIL dm_wb_address got %0h want 01", bus.mem_address); end
    tests++; if (bus.mem_writedata !== 32'h4534AA12) begin fails++; $display("FAIL dm_wb_data got %0h want 4534aa12", bus.mem_writedata); end
    for (int i = 0; i < 20 && !bus.mem_read; i++) begin @(negedge clk); #1; end
    tests++; if ({bus.mem_write, bus.mem_read} !== 2'b01) begin fails++; $display("FAIL dm_fetch_req got %0b want 01", {bus.mem_write, bus.mem_read}); end
    tests++; if (bus.mem_address !== 6'h09) begin fails++; $display("FAIL dm_fetch_address got %0h want 09", bus.mem_address); end
    wait_ready(c);
    tests++; if (bus.readdata !== 8'h2B) begin fails++; $display("FAIL dm_readdata got %0h want 2b (cyc %0d)", bus.readdata, c); end
    tests++; if (mem[1] !== 32'h4534AA12) begin fails++; $display("FAIL dm_mem_block1 got %0h want 4534aa12", mem[1]); end
  endtask

  task automatic test_drop_mid_fetch;
    bus.read = 1'b1; bus.address = 8'h10;
    @(negedge clk); #1;
    tests++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL drop_mem_read got %0h want 1", bus.mem_read); end
    bus.read = 1'b0;
    for (int i = 0; i < 20 && bus.mem_read; i++) begin @(negedge clk); #1; end
    tests++; if (bus.mem_read !== 1'b0) begin fails++; $display("FAIL drop_fill_done got %0h want 0", bus.mem_read); end
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL drop_busywait got %0h want 0", bus.busywait); end
    bus.read = 1'b1; #1;
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL drop_rehit_busy got %0h want 0", bus.busywait); end
    tests++; if (bus.readdata !== 8'h15) begin fails++; $display("FAIL drop_rehit_data got %0h want 15", bus.readdata); end
  endtask

  task automatic test_reset_mid_writeback;
    int c;
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h24; bus.writedata = 8'h77; #1;
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL rwb_store_busy got %0h want 0", bus.busywait); end
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b1; bus.address = 8'h04;
    @(negedge clk); #1;
    tests++; if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL rwb_wb_req got %0h want 1", bus.mem_write); end
    tests++; if (bus.mem_address !== 6'h09) begin fails++; $display("FAIL rwb_wb_address got %0h want 09", bus.mem_address); end
    tests++; if (bus.mem_writedata !== 32'h4D3C2B77) begin fails++; $display("FAIL rwb_wb_data got %0h want 4d3c2b77", bus.mem_writedata); end
    rst_n = 1'b0; bus.read = 1'b0;
    @(negedge clk); #1;
    tests++; if ({bus.mem_write, bus.mem_read} !== 2'b00) begin fails++; $display("FAIL rwb_abort_req got %0b want 00", {bus.mem_write, bus.mem_read}); end
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL rwb_abort_busy got %0h want 0", bus.busywait); end
    rst_n = 1'b1; bus.read = 1'b1; bus.address = 8'h24; #1;
    tests++; if (bus.busywait !== 1'b1) begin fails++; $display("FAIL rwb_remiss_busy got %0h want 1", bus.busywait); end
    @(negedge clk); #1;
    tests++; if ({bus.mem_write, bus.mem_read} !== 2'b01) begin fails++; $display("FAIL rwb_clean_fetch got %0b want 01", {bus.mem_write, bus.mem_read}); end
    wait_ready(c);
    tests++; if (bus.readdata !== 8'h1A) begin fails++; $display("FAIL rwb_lost_dirty got %0h want 1a (cyc %0d)", bus.readdata, c); end
    tests++; if (mem[9] !== 32'h4D3C2B1A) begin fails++; $display("FAIL rwb_mem_block9 got %0h want 4d3c2b1a", mem[9]); end
  endtask

  task automatic test_read_write_together;
    int c;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h00;
    wait_ready(c);
    tests++; if (bus.readdata !== 8'h11) begin fails++; $display("FAIL rw_fill got %0h want 11 (cyc %0d)", bus.readdata, c); end
    bus.write = 1'b1; bus.writedata = 8'h5A; #1;
    tests++; if (bus.readdata !== 8'h00) begin fails++; $display("FAIL rw_readdata got %0h want 00", bus.readdata); end
    tests++; if (bus.busywait !== 1'b0) begin fails++; $display("FAIL rw_busywait got %0h want 0", bus.busywait); end
    @(negedge clk);
    bus.write = 1'b0; #1;
    tests++; if (bus.readdata !== 8'h5A) begin fails++; $display("FAIL rw_stored got %0h want 5a", bus.readdata); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_drop_mid_fetch();
    test_reset_mid_writeback();
    test_read_write_together();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
